decodificador_display: RTL and testbench
========================================

// Module: decodificador_display
// PURPOSE
//  Monitors a multiplexed, common-anode 7-segment display bus and recovers the hex digit shown in each position.
//  It is the inverse of the team's hex->segment encoder.
//  Used in board self-test, where it observes the segment/anode pins driven by the display path.
//  Each digit is committed only after its pattern has been held stable, so scan transitions are filtered out.
// PARAMETERS
//  N_DIGITOS  4  number of multiplexed digit positions (anodos width)
//  ESTAVEL    4  consecutive cycles an (anodos,segmentos) pair must hold before commit (>=1)
// PORTS
//  clk        in   1            single clock, rising edge
//  rst        in   1            asynchronous, active-high reset
//  segmentos  in   7            active-low segments {g,f,e,d,c,b,a}
//  anodos     in   N_DIGITOS    active-low digit enables; bit i selects position i
//  digitos    out  4*N_DIGITOS  decoded nibbles; position i at [4i+3:4i]
//  valido     out  N_DIGITOS    valido[i]=1 while digitos[i] holds a decoded legal pattern
//  novo       out  1            1-cycle pulse on each legal commit
//  erro       out  1            1-cycle pulse on each illegal-pattern commit
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation): digitos=0, valido=0, novo=0, erro=0,
//   input regs=all-ones, stability counter=0, commit-done flag=0.
//  Input stage: segmentos/anodos registered once (seg_r, an_r) every cycle; all decisions use the registered values.
//  Legal table (seg_r -> nibble):
//   0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000
//   8:0000000 9:0011000 A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110
//  Blank pattern: 1111111. Every other pattern is illegal.
//  Selection: an_r must have exactly one bit low. If zero or >1 bits are low:
//   counter:=0 and commit-done:=0; no output changes.
//  Stability: if (an_r,seg_r) equals the previous cycle's pair and the selection is valid,
//   counter increments, saturating at ESTAVEL. Otherwise counter:=1 when the selection is valid, and commit-done:=0.
//  Commit: fires once, in the cycle where counter reaches ESTAVEL and commit-done=0; then commit-done:=1.
//   No re-commit until the pair changes.
//   legal   -> digitos[i]:=nibble, valido[i]:=1, novo=1 for exactly that cycle
//   blank   -> valido[i]:=0, digitos[i] kept, no pulse
//   illegal -> valido[i]:=0, digitos[i] kept, erro=1 for exactly that cycle
//  Latency: a pair applied to the pins at edge t, and held, commits at edge t+1+ESTAVEL.
//   Outputs are registered and change on that edge.
//  ESTAVEL=1: commit on the first registered cycle of a valid selection.
//  novo and erro are never high together, and both default to 0 in every other cycle.
//  Other positions' digitos/valido remain unchanged on any commit.
//  Scan wrap (position N-1 -> 0) needs no special handling; each change of position restarts stability.
//  Counter width = $clog2(ESTAVEL+1).
// STRUCTURE
//  Package display_pkg:
//   - SEG_0..SEG_F and SEG_APAGADO 7-bit localparams
//   - N_SEGMENTOS=7
//   - onehot-low check function
//  Sub-module decodificador_segmentos (combinational):
//   - in: seg[6:0]
//   - out: valor[3:0], legal, apagado
//   - same table; valor=0 when not legal
//  Top module holds:
//   - input regs and previous-pair reg
//   - counter and commit-done flag
//   - per-position digit/valid registers
//   - pulse logic
// TESTING (ESTAVEL=4, N_DIGITOS=4)
//  1. Reset mid-run: rst=1 asynchronously
//     -> digitos=0, valido=0, novo=erro=0 before the next clk edge.
//  2. anodos=1110, segmentos=0100100, held 10 cycles
//     -> on edge 5: digitos[3:0]=2, valido=0001, novo pulses exactly once.
//  3. Scan with 6 cycles/position showing 1,A,d,F on positions 0..3
//     -> digitos=16'hFDA1, valido=1111, 4 novo pulses.
//  4. anodos=1011, segmentos=1010101 (illegal) for 6 cycles
//     -> erro pulses once, valido[2]=0, digitos[11:8] unchanged.
//  5. anodos=0110 (two low), or a pattern held only 3 cycles
//     -> no novo/erro and no output change. Then blank 1111111 on position 0
//     -> valido[0]=0, no pulse.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared segment encodings and scan-select helper for the 7-segment display monitor.
package display_pkg;

    localparam int N_SEGMENTOS = 7;

    // Active-low {g,f,e,d,c,b,a}, matching the hex->segment encoder.
    localparam logic [N_SEGMENTOS-1:0] SEG_0       = 7'b1000000;
    localparam logic [N_SEGMENTOS-1:0] SEG_1       = 7'b1111001;
    localparam logic [N_SEGMENTOS-1:0] SEG_2       = 7'b0100100;
    localparam logic [N_SEGMENTOS-1:0] SEG_3       = 7'b0110000;
    localparam logic [N_SEGMENTOS-1:0] SEG_4       = 7'b0011001;
    localparam logic [N_SEGMENTOS-1:0] SEG_5       = 7'b0010010;
    localparam logic [N_SEGMENTOS-1:0] SEG_6       = 7'b0000010;
    localparam logic [N_SEGMENTOS-1:0] SEG_7       = 7'b1111000;
    localparam logic [N_SEGMENTOS-1:0] SEG_8       = 7'b0000000;
    localparam logic [N_SEGMENTOS-1:0] SEG_9       = 7'b0011000;
    localparam logic [N_SEGMENTOS-1:0] SEG_A       = 7'b0001000;
    localparam logic [N_SEGMENTOS-1:0] SEG_B       = 7'b0000011;
    localparam logic [N_SEGMENTOS-1:0] SEG_C       = 7'b1000110;
    localparam logic [N_SEGMENTOS-1:0] SEG_D       = 7'b0100001;
    localparam logic [N_SEGMENTOS-1:0] SEG_E       = 7'b0000110;
    localparam logic [N_SEGMENTOS-1:0] SEG_F       = 7'b0001110;
    localparam logic [N_SEGMENTOS-1:0] SEG_APAGADO = 7'b1111111;

    // Takes the anode vector already inverted to active-high; true when exactly one digit is enabled.
    function automatic logic seletor_unico(input logic [31:0] ativos);
        return (ativos != '0) && ((ativos & (ativos - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/decodificador_segmentos.sv
// decodificador_segmentos: combinational segment pattern -> hex nibble, flagging legal and blank patterns.
module decodificador_segmentos
    import display_pkg::*;
(
    input  logic [N_SEGMENTOS-1:0] seg,
    output logic [3:0]             valor,
    output logic                   legal,
    output logic                   apagado
);

    always_comb begin
        legal = 1'b1;
        valor = 4'h0;
        case (seg)
            SEG_0:   valor = 4'h0;
            SEG_1:   valor = 4'h1;
            SEG_2:   valor = 4'h2;
            SEG_3:   valor = 4'h3;
            SEG_4:   valor = 4'h4;
            SEG_5:   valor = 4'h5;
            SEG_6:   valor = 4'h6;
            SEG_7:   valor = 4'h7;
            SEG_8:   valor = 4'h8;
            SEG_9:   valor = 4'h9;
            SEG_A:   valor = 4'hA;
            SEG_B:   valor = 4'hB;
            SEG_C:   valor = 4'hC;
            SEG_D:   valor = 4'hD;
            SEG_E:   valor = 4'hE;
            SEG_F:   valor = 4'hF;
            default: legal = 1'b0;
        endcase
        apagado = (seg == SEG_APAGADO);
    end

endmodule

// File: rtl/decodificador_display.sv
// decodificador_display: recovers the hex digit of each position on a multiplexed common-anode
// 7-segment bus, committing a position only after its (anode, segment) pair has been held stable.
module decodificador_display
    import display_pkg::*;
#(
    parameter int N_DIGITOS = 4,
    parameter int ESTAVEL   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SEGMENTOS-1:0] segmentos,
    input  logic [N_DIGITOS-1:0]   anodos,
    output logic [4*N_DIGITOS-1:0] digitos,
    output logic [N_DIGITOS-1:0]   valido,
    output logic                   novo,
    output logic                   erro
);

    localparam int             CW      = $clog2(ESTAVEL + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(ESTAVEL);

    logic [N_SEGMENTOS-1:0] seg_q, seg_p_q;
    logic [N_DIGITOS-1:0]   an_q, an_p_q, an_ativo;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic [4*N_DIGITOS-1:0] digitos_q, digitos_d;
    logic [N_DIGITOS-1:0]   valido_q, valido_d;
    logic                   novo_q, novo_d, erro_q, erro_d;
    logic [3:0]             valor;
    logic                   legal, apagado, sel_ok, mesmo, commit;

    decodificador_segmentos u_seg (
        .seg     (seg_q),
        .valor   (valor),
        .legal   (legal),
        .apagado (apagado)
    );

    assign an_ativo = ~an_q;
    assign sel_ok   = seletor_unico(32'(an_ativo));
    assign mesmo    = (an_q == an_p_q) && (seg_q == seg_p_q);

    // done_q only survives while the pair is unchanged, so a held pair commits exactly once.
    always_comb begin
        cnt_d     = !sel_ok ? '0 : !mesmo ? CW'(1) : (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CW'(1);
        commit    = sel_ok && (cnt_d == CNT_MAX) && !(mesmo && done_q);
        done_d    = sel_ok && (commit || (mesmo && done_q));
        digitos_d = digitos_q;
        valido_d  = valido_q;
        for (int k = 0; k < N_DIGITOS; k++) begin
            if (commit && an_ativo[k]) begin
                digitos_d[4*k +: 4] = legal ? valor : digitos_q[4*k +: 4];
                valido_d[k]         = legal;
            end
        end
        novo_d = commit && legal;
        erro_d = commit && !legal && !apagado;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q     <= '1;
            an_q      <= '1;
            seg_p_q   <= '1;
            an_p_q    <= '1;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            digitos_q <= '0;
            valido_q  <= '0;
            novo_q    <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            seg_q     <= segmentos;
            an_q      <= anodos;
            seg_p_q   <= seg_q;
            an_p_q    <= an_q;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            digitos_q <= digitos_d;
            valido_q  <= valido_d;
            novo_q    <= novo_d;
            erro_q    <= erro_d;
        end
    end

    assign digitos = digitos_q;
    assign valido  = valido_q;
    assign novo    = novo_q;
    assign erro    = erro_q;

endmodule

// File: tb/tb_decodificador_display.sv
// tb_decodificador_display: directed scan scenarios checked every cycle against a history-window model.
module tb_decodificador_display;

    localparam int N = 4;
    localparam int E = 4;

    logic          clk, rst;
    logic [6:0]    segmentos;
    logic [N-1:0]  anodos;
    logic [4*N-1:0] digitos;
    logic [N-1:0]  valido;
    logic          novo, erro;

    decodificador_display #(.N_DIGITOS(N), .ESTAVEL(E)) dut (
        .clk       (clk),
        .rst       (rst),
        .segmentos (segmentos),
        .anodos    (anodos),
        .digitos   (digitos),
        .valido    (valido),
        .novo      (novo),
        .erro      (erro)
    );

    int compared = 0, mismatched = 0, novo_cnt = 0, erro_cnt = 0;

    logic [6:0]     tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    logic [10:0]    hist [$];
    logic [4*N-1:0] m_dig;
    logic [N-1:0]   m_val;
    logic           m_novo, m_erro;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Commit when the last E registered pairs are identical with one anode low, and the pair before differs.
    function automatic logic janela_estavel();
        int s = hist.size();
        logic [10:0] p;
        if (s < E + 1) return 1'b0;
        p = hist[s-1];
        if ($countones(~p[10:7]) != 1) return 1'b0;
        for (int j = 1; j < E; j++) if (hist[s-1-j] != p) return 1'b0;
        return hist[s-1-E] != p;
    endfunction

    task automatic aplicar_modelo(input logic [10:0] p);
        int pos = 0;
        int idx = -1;
        for (int k = 0; k < N; k++) if (!p[7+k]) pos = k;
        for (int v = 0; v < 16; v++) if (tab[v] == p[6:0]) idx = v;
        m_val[pos] = (idx >= 0);
        if (idx >= 0) begin
            m_dig[4*pos +: 4] = 4'(idx);
            m_novo = 1'b1;
        end else if (p[6:0] != 7'h7F) m_erro = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_dig = '0; m_val = '0; m_novo = 0; m_erro = 0;
                hist.delete();
                hist.push_back('1);
            end else begin
                m_novo = 0; m_erro = 0;
                if (janela_estavel()) aplicar_modelo(hist[hist.size()-1]);
                hist.push_back({anodos, segmentos});
                if (hist.size() > 8) void'(hist.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        compared++;
        if ({digitos, valido, novo, erro} !== {m_dig, m_val, m_novo, m_erro}) begin
            mismatched++;
            $display("FAIL cycle t=%0t: got dig=%h val=%b novo=%b erro=%b, want dig=%h val=%b novo=%b erro=%b",
                     $time, digitos, valido, novo, erro, m_dig, m_val, m_novo, m_erro);
        end
        novo_cnt += int'(novo);
        erro_cnt += int'(erro);
    end

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h", nome, got, want);
        end
    endtask

    task automatic aplica(input logic [N-1:0] a, input logic [6:0] s, input int n);
        anodos = a;
        segmentos = s;
        repeat (n) @(negedge clk);
        #1;
    endtask

    int n0, e0;

    initial begin
        rst = 1; anodos = '1; segmentos = '1;
        repeat (3) @(negedge clk);
        #1 rst = 0;
        chk("reset_digitos", 32'(digitos), 32'h0);
        chk("reset_valido", 32'(valido), 32'h0);

        n0 = novo_cnt;
        aplica(4'b1110, 7'b0100100, 4);
        chk("pre_commit_valido", 32'(valido), 32'h0);
        aplica(4'b1110, 7'b0100100, 1);
        chk("edge5_digito0", 32'(digitos[3:0]), 32'h2);
        chk("edge5_valido", 32'(valido), 32'b0001);
        aplica(4'b1110, 7'b0100100, 5);
        chk("t2_novo_pulses", 32'(novo_cnt - n0), 32'd1);

        n0 = novo_cnt;
        aplica(4'b1110, 7'b1111001, 6);
        aplica(4'b1101, 7'b0001000, 6);
        aplica(4'b1011, 7'b0100001, 6);
        aplica(4'b0111, 7'b0001110, 6);
        chk("scan_digitos", 32'(digitos), 32'hFDA1);
        chk("scan_valido", 32'(valido), 32'hF);
        chk("scan_novo_pulses", 32'(novo_cnt - n0), 32'd4);

        e0 = erro_cnt; n0 = novo_cnt;
        aplica(4'b1011, 7'b1010101, 6);
        chk("illegal_erro_pulses", 32'(erro_cnt - e0), 32'd1);
        chk("illegal_valido", 32'(valido), 32'b1011);
        chk("illegal_digitos", 32'(digitos), 32'hFDA1);

        e0 = erro_cnt;
        aplica(4'b0110, 7'b0100100, 6);
        aplica(4'b1101, 7'b0000000, 3);
        chk("nosel_short_digitos", 32'(digitos), 32'hFDA1);
        chk("nosel_short_valido", 32'(valido), 32'b1011);
        aplica(4'b1110, 7'b1111111, 6);
        chk("blank_valido", 32'(valido), 32'b1010);
        chk("blank_digitos", 32'(digitos), 32'hFDA1);
        chk("t5_no_pulses", 32'((novo_cnt - n0) + (erro_cnt - e0)), 32'd0);

        aplica(4'b1101, 7'b0010010, 2);
        #2 rst = 1;
        #1;
        chk("async_rst_digitos", 32'(digitos), 32'h0);
        chk("async_rst_valido", 32'(valido), 32'h0);
        chk("async_rst_pulses", 32'({novo, erro}), 32'h0);
        @(negedge clk);
        #1 rst = 0;
        aplica(4'b0111, 7'b1000110, 6);
        chk("post_rst_digitos", 32'(digitos), 32'hC000);
        chk("post_rst_valido", 32'(valido), 32'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
